// File: rtl/aip_slave_if.sv
// AIP host-protocol responder: register/memory decode plus core-side port.
// Optional AIP_PTR_READBACK_EN: reads of codes 1/3 return ptr_y/ptr_z.
module aip_slave_if #(
    parameter int          DATAWIDTH   = 32,
    parameter int          MEM_Y_DEPTH = 32,
    parameter int          MEM_Z_DEPTH = 64,
    parameter logic [31:0] IP_ID_VALUE = 32'h1000_500B,
    localparam int         YW = $clog2(MEM_Y_DEPTH),
    localparam int         ZW = $clog2(MEM_Z_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic [DATAWIDTH-1:0] data_in,
    output logic [DATAWIDTH-1:0] data_out,
    input  logic                 write,
    input  logic                 read,
    input  logic                 start,
    input  logic [4:0]           conf_dbus,
    output logic                 int_req,
    output logic                 core_start,
    input  logic                 core_busy,
    input  logic                 core_done,
    output logic [4:0]           core_size_y,
    input  logic [YW-1:0]        core_y_addr,
    output logic [DATAWIDTH-1:0] core_y_data,
    input  logic                 core_z_we,
    input  logic [ZW-1:0]        core_z_addr,
    input  logic [DATAWIDTH-1:0] core_z_data
);

    localparam logic [4:0] CODE_Y_DATA = 5'd0;
    localparam logic [4:0] CODE_Y_PTR  = 5'd1;
    localparam logic [4:0] CODE_Z_DATA = 5'd2;
    localparam logic [4:0] CODE_Z_PTR  = 5'd3;
    localparam logic [4:0] CODE_CONF   = 5'd4;
    localparam logic [4:0] CODE_CPTR   = 5'd5;
    localparam logic [4:0] CODE_STATUS = 5'd30;
    localparam logic [4:0] CODE_ID     = 5'd31;

    logic [DATAWIDTH-1:0] mem_y [MEM_Y_DEPTH];
    logic [DATAWIDTH-1:0] mem_z [MEM_Z_DEPTH];

    logic [YW-1:0]        ptr_y;
    logic [ZW-1:0]        ptr_z;
    logic [DATAWIDTH-1:0] conf;
    logic [7:0]           mask;
    logic [7:0]           flags;

    logic                 wr_en;
    logic                 rd_en;
    logic                 st_en;
    logic [31:0]          status_word;
    logic [DATAWIDTH-1:0] rd_data;
    logic [7:0]           flags_clr;
    logic [7:0]           flags_set;

    assign wr_en       = en_s & write;
    assign rd_en       = en_s & read;
    assign st_en       = en_s & start;
    assign core_size_y = conf[4:0];
    assign status_word = {7'd0, core_busy, mask, 8'd0, flags};

    always_comb begin
        rd_data = '0;
        case (conf_dbus)
            CODE_Z_DATA: rd_data = mem_z[ptr_z];
            CODE_CONF:   rd_data = conf;
            CODE_STATUS: rd_data = DATAWIDTH'(status_word);
            CODE_ID:     rd_data = DATAWIDTH'(IP_ID_VALUE);
`ifdef AIP_PTR_READBACK_EN
            CODE_Y_PTR:  rd_data = DATAWIDTH'(ptr_y);
            CODE_Z_PTR:  rd_data = DATAWIDTH'(ptr_z);
`endif
            default:     rd_data = '0;
        endcase
    end

    // Set sources are OR-ed after the clear so a coincident set wins.
    always_comb begin
        flags_clr = '0;
        if (wr_en && conf_dbus == CODE_STATUS)
            flags_clr = data_in[7:0];
        flags_set = {6'd0, st_en & core_busy, core_done};
    end

    // Memory arrays carry no reset so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && conf_dbus == CODE_Y_DATA)
            mem_y[ptr_y] <= data_in;
        if (core_z_we)
            mem_z[core_z_addr] <= core_z_data;
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            data_out    <= '0;
            int_req     <= 1'b1;
            core_start  <= 1'b0;
            core_y_data <= '0;
            conf        <= '0;
            ptr_y       <= '0;
            ptr_z       <= '0;
            mask        <= '0;
            flags       <= '0;
        end else begin
            core_y_data <= mem_y[core_y_addr];
            core_start  <= st_en & ~core_busy;
            int_req     <= ~|(flags & mask);
            flags       <= (flags & ~flags_clr) | flags_set;
            if (rd_en) begin
                data_out <= rd_data;
                if (conf_dbus == CODE_Z_DATA)
                    ptr_z <= ptr_z + ZW'(1);
            end
            if (wr_en) begin
                case (conf_dbus)
                    CODE_Y_DATA: ptr_y <= ptr_y + YW'(1);
                    CODE_Y_PTR:  ptr_y <= data_in[YW-1:0];
                    CODE_Z_PTR:  ptr_z <= data_in[ZW-1:0];
                    CODE_CONF:   conf  <= data_in;
                    CODE_STATUS: mask  <= data_in[23:16];
                    CODE_CPTR:   ;
                    default:     ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aip_slave_if.sv
// Self-checking bench for aip_slave_if: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_aip_slave_if;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        en_s;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        write;
    logic        read;
    logic        start;
    logic [4:0]  conf_dbus;
    logic        int_req;
    logic        core_start;
    logic        core_busy;
    logic        core_done;
    logic [4:0]  core_size_y;
    logic [4:0]  core_y_addr;
    logic [31:0] core_y_data;
    logic        core_z_we;
    logic [5:0]  core_z_addr;
    logic [31:0] core_z_data;

    aip_slave_if dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s),
        .data_in(data_in), .data_out(data_out),
        .write(write), .read(read), .start(start),
        .conf_dbus(conf_dbus), .int_req(int_req),
        .core_start(core_start), .core_busy(core_busy),
        .core_done(core_done), .core_size_y(core_size_y),
        .core_y_addr(core_y_addr), .core_y_data(core_y_data),
        .core_z_we(core_z_we), .core_z_addr(core_z_addr),
        .core_z_data(core_z_data)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: host-visible registers and both memories.
    logic [31:0] m_y [32];
    logic [31:0] m_z [64];
    int          m_py, m_pz;
    logic [31:0] m_conf, m_dout, m_ydata;
    logic [7:0]  m_mask, m_flags;
    logic        m_int, m_start;

    typedef struct {
        logic        wr, rd, st, busy, done;
        logic [4:0]  code;
        logic [31:0] din;
        logic [31:0] dout;
        logic        cs;
        logic        irq;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic wr, logic rd, logic st, logic busy,
                                logic done, logic [4:0] code,
                                logic [31:0] din, logic [31:0] dout,
                                logic cs, logic irq);
        vec_t v;
        v.wr = wr; v.rd = rd; v.st = st; v.busy = busy; v.done = done;
        v.code = code; v.din = din; v.dout = dout; v.cs = cs; v.irq = irq;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dout = 0; m_int = 1; m_start = 0; m_ydata = 0;
        m_conf = 0; m_py = 0; m_pz = 0; m_mask = 0; m_flags = 0;
    endtask

    task automatic idle();
        en_s = 1; write = 0; read = 0; start = 0; conf_dbus = 0;
        data_in = 0; core_done = 0; core_z_we = 0;
    endtask

    task automatic bus(logic w, logic r, logic s, logic [4:0] c,
                       logic [31:0] d);
        write = w; read = r; start = s; conf_dbus = c; data_in = d;
    endtask

    // One clock: inputs are already driven; advance the model by one
    // transaction using the values present at the edge.
    task automatic step();
        logic e, w, r, s, b, d, zwe;
        logic [4:0]  c, ya;
        logic [5:0]  za;
        logic [31:0] di, zd;
        logic [7:0]  f0, k0;
        e = en_s; w = write; r = read; s = start; b = core_busy;
        d = core_done; zwe = core_z_we; c = conf_dbus; ya = core_y_addr;
        za = core_z_addr; di = data_in; zd = core_z_data;
        @(posedge clk);
        #1;
        f0 = m_flags;
        k0 = m_mask;
        m_int   = ((f0 & k0) == 8'd0);
        m_ydata = m_y[ya];
        m_start = 0;
        if (e && r) begin
            case (c)
                5'd2: begin
                    m_dout = m_z[m_pz];
                    m_pz = (m_pz + 1) % 64;
                end
                5'd4:  m_dout = m_conf;
                5'd30: m_dout = {7'd0, b, k0, 8'd0, f0};
                5'd31: m_dout = 32'h1000_500B;
`ifdef AIP_PTR_READBACK_EN
                5'd1:  m_dout = 32'(m_py);
                5'd3:  m_dout = 32'(m_pz);
`endif
                default: m_dout = 0;
            endcase
        end
        if (e && w) begin
            case (c)
                5'd0: begin
                    m_y[m_py] = di;
                    m_py = (m_py + 1) % 32;
                end
                5'd1:  m_py = int'(di % 32);
                5'd3:  m_pz = int'(di % 64);
                5'd4:  m_conf = di;
                5'd30: begin
                    m_mask  = di[23:16];
                    m_flags = m_flags & ~di[7:0];
                end
                default: ;
            endcase
        end
        if (e && s) begin
            if (b) m_flags = m_flags | 8'h02;
            else   m_start = 1;
        end
        if (d) m_flags = m_flags | 8'h01;
        if (zwe) m_z[za] = zd;
    endtask

    task automatic check_all(string tag);
        chk({tag, ".data_out"}, data_out, m_dout);
        chk({tag, ".core_start"}, 32'(core_start), 32'(m_start));
        chk({tag, ".int_req"}, 32'(int_req), 32'(m_int));
        chk({tag, ".core_y_data"}, core_y_data, m_ydata);
        chk({tag, ".core_size_y"}, 32'(core_size_y), 32'(m_conf[4:0]));
    endtask

    initial begin
        tbl[0]  = mk(0,1,0,0,0,5'd31,32'h0,32'h1000_500B,0,1);
        tbl[1]  = mk(0,1,0,0,0,5'd30,32'h0,32'h0,0,1);
        tbl[2]  = mk(1,0,0,0,0,5'd4,32'd5,32'h0,0,1);
        tbl[3]  = mk(0,1,0,0,0,5'd4,32'h0,32'd5,0,1);
        tbl[4]  = mk(0,0,1,0,0,5'd0,32'h0,32'd5,1,1);
        tbl[5]  = mk(0,0,0,0,0,5'd0,32'h0,32'd5,0,1);
        tbl[6]  = mk(0,0,1,1,0,5'd0,32'h0,32'd5,0,1);
        tbl[7]  = mk(0,1,0,1,0,5'd30,32'h0,32'h0100_0002,0,1);
        tbl[8]  = mk(1,0,0,0,0,5'd30,32'h0001_0000,32'h0100_0002,0,1);
        tbl[9]  = mk(0,0,0,0,1,5'd0,32'h0,32'h0100_0002,0,1);
        tbl[10] = mk(0,0,0,0,0,5'd0,32'h0,32'h0100_0002,0,0);
        tbl[11] = mk(1,0,0,0,0,5'd30,32'h0001_0001,32'h0100_0002,0,0);
        tbl[12] = mk(0,0,0,0,0,5'd0,32'h0,32'h0100_0002,0,1);
        tbl[13] = mk(0,1,0,0,0,5'd30,32'h0,32'h0001_0002,0,1);
        tbl[14] = mk(1,0,0,0,1,5'd30,32'h0001_0003,32'h0001_0002,0,1);
        tbl[15] = mk(0,1,0,0,0,5'd30,32'h0,32'h0001_0001,0,0);
        tbl[16] = mk(0,1,0,0,0,5'd5,32'h0,32'h0,0,0);
        tbl[17] = mk(1,0,0,0,0,5'd31,32'h0,32'h0,0,0);
        tbl[18] = mk(0,1,0,0,0,5'd31,32'h0,32'h1000_500B,0,0);
        tbl[19] = mk(0,1,0,0,0,5'd7,32'h0,32'h0,0,0);

        rst_a = 1;
        idle();
        core_busy = 0; core_y_addr = 0; core_z_addr = 0; core_z_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_a = 0;

        // Directed register/start/interrupt table
        foreach (tbl[i]) begin
            bus(tbl[i].wr, tbl[i].rd, tbl[i].st, tbl[i].code, tbl[i].din);
            core_busy = tbl[i].busy;
            core_done = tbl[i].done;
            step();
            chk($sformatf("tbl%0d.data_out", i), data_out, tbl[i].dout);
            chk($sformatf("tbl%0d.core_start", i), 32'(core_start),
                32'(tbl[i].cs));
            chk($sformatf("tbl%0d.int_req", i), 32'(int_req),
                32'(tbl[i].irq));
            idle();
            core_busy = 0;
        end
        chk("conf.size_y", 32'(core_size_y), 32'd5);

        // Y fill, core read latency, pointer wrap with collision
        bus(1, 0, 0, 5'd1, 32'd0);
        step();
        for (int i = 0; i < 32; i++) begin
            bus(1, 0, 0, 5'd0, 32'(i));
            step();
        end
        idle();
        core_y_addr = 5;
        step();
        chk("y.addr5", core_y_data, 32'd5);
        core_y_addr = 0;
        bus(1, 0, 0, 5'd0, 32'd99);
        step();
        chk("y.collide_old", core_y_data, 32'd0);
        idle();
        step();
        chk("y.wrap", core_y_data, 32'd99);

        // Z fill from the core, then sequential host reads
        for (int i = 0; i < 64; i++) begin
            core_z_we = 1; core_z_addr = 6'(i); core_z_data = 32'(100 + i);
            step();
        end
        idle();
        bus(1, 0, 0, 5'd3, 32'd0);
        step();
        for (int i = 0; i < 15; i++) begin
            bus(0, 1, 0, 5'd2, 32'd0);
            step();
            chk($sformatf("z.rd%0d", i), data_out, 32'(100 + i));
        end
        idle();

        // Reset mid-stream while a start pulse is pending
        bus(0, 0, 1, 5'd0, 32'd0);
        step();
        chk("rst.pre_start", 32'(core_start), 32'd1);
        idle();
        #2 rst_a = 1;
        #1;
        model_reset();
        check_all("rst.mid");
        #1 rst_a = 0;
        bus(0, 1, 0, 5'd30, 32'd0);
        step();
        chk("rst.status", data_out, 32'd0);
        chk("rst.int_req", 32'(int_req), 32'd1);
        bus(0, 1, 0, 5'd2, 32'd0);
        step();
        chk("rst.ptr_z", data_out, 32'd100);
        bus(1, 0, 0, 5'd0, 32'h0000_00AB);
        core_y_addr = 0;
        step();
        idle();
        step();
        chk("rst.ptr_y", core_y_data, 32'h0000_00AB);
        check_all("rst.post");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [4:0] codes [9];
            codes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd30, 5'd31,
                      5'($urandom)};
            en_s        = ($urandom % 8) != 0;
            write       = 1'($urandom);
            read        = 1'($urandom);
            start       = ($urandom % 6) == 0;
            conf_dbus   = codes[$urandom % 9];
            data_in     = $urandom;
            core_busy   = 1'($urandom);
            core_done   = ($urandom % 8) == 0;
            core_y_addr = 5'($urandom);
            core_z_we   = 1'($urandom);
            core_z_addr = 6'($urandom);
            core_z_data = $urandom;
            step();
            check_all($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
